writeback_regfile: RTL and testbench

- Writeback stage and architectural register file of the single-cycle RV32I core, directly downstream of the memory stage.
- Consumes the memory stage's `memory_out` (already muxed between ALU result and load data), decodes rd and write enable from `instr`, and commits the write on the clock edge.
- Serves two combinational read ports to decode/execute.
- Maintains cycle/retire counters, a registered commit trace for difftest, and an ebreak halt state machine.

---
 rtl/writeback_regfile.sv | 88 ++++++++
 tb/tb_writeback_regfile.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - RV32I writeback stage: register file, counters, commit trace, ebreak halt
module writeback_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  input  logic [XLEN-1:0]  memory_out,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic [XLEN-1:0]  rdata1,
  output logic [XLEN-1:0]  rdata2,
  output logic             halt,
  output logic [XLEN-1:0]  halt_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic             commit_valid,
  output logic [31:0]      commit_pc,
  output logic [4:0]       commit_rd,
  output logic [XLEN-1:0]  commit_wdata
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  state_t          state;
  logic [XLEN-1:0] regs [NREG];
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic            writes_rd;
  logic            reg_we;
  logic            is_ebreak;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];

  always_comb begin
    writes_rd = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b0000011, 7'b0010011, 7'b0110011: writes_rd = 1'b1;
      default:                            writes_rd = 1'b0;
    endcase
  end

  assign reg_we    = valid && (state == RUN) && writes_rd;
  assign is_ebreak = valid && (state == RUN) && (instr == EBREAK);

  // Reads see only stored state; a bypass would loop through execute/memory.
  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      halt         <= 1'b0;
      halt_code    <= '0;
      cycle_cnt    <= '0;
      instret_cnt  <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_rd    <= '0;
      commit_wdata <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == RUN) begin
      cycle_cnt    <= cycle_cnt + CNT_W'(1);
      if (valid) instret_cnt <= instret_cnt + CNT_W'(1);
      if (reg_we && rd != 5'd0) regs[rd] <= memory_out;
      commit_valid <= valid;
      commit_pc    <= pc;
      commit_rd    <= reg_we ? rd : 5'd0;
      commit_wdata <= (reg_we && rd != 5'd0) ? memory_out : '0;
      if (is_ebreak) begin
        state     <= HALTED;
        halt      <= 1'b1;
        halt_code <= regs[10];
      end
    end else begin
      commit_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - randomized self-checking bench for writeback_regfile
module tb_writeback_regfile;

  localparam int SW = 1 + 32 + 64 + 64 + 1 + 32 + 5 + 32;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk, rst, valid;
  logic [31:0] instr, pc, memory_out;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, halt_code, commit_pc, commit_wdata;
  logic        halt, commit_valid;
  logic [63:0] cycle_cnt, instret_cnt;
  logic [4:0]  commit_rd;

  writeback_regfile dut (
    .clk(clk), .rst(rst), .valid(valid), .instr(instr), .pc(pc),
    .memory_out(memory_out), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .halt(halt), .halt_code(halt_code),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_rd(commit_rd), .commit_wdata(commit_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Architectural reference: what the committed machine state should be.
  logic [31:0] m_regs [32];
  logic        m_halt, m_cv;
  logic [31:0] m_hcode, m_cpc, m_cwd;
  logic [63:0] m_cycle, m_instret;
  logic [4:0]  m_crd;

  function automatic bit op_writes(input logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                      7'b0000011, 7'b0010011, 7'b0110011};
  endfunction

  function automatic logic [SW-1:0] obs();
    return {halt, halt_code, cycle_cnt, instret_cnt, commit_valid, commit_pc, commit_rd, commit_wdata};
  endfunction

  function automatic logic [SW-1:0] expv();
    return {m_halt, m_hcode, m_cycle, m_instret, m_cv, m_cpc, m_crd, m_cwd};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_halt = 0; m_cv = 0; m_hcode = '0; m_cpc = '0; m_cwd = '0;
    m_cycle = '0; m_instret = '0; m_crd = '0;
  endtask

  task automatic model_edge();
    bit we;
    logic [4:0] rd;
    if (m_halt) begin
      m_cv = 0;
    end else begin
      rd = instr[11:7];
      we = valid && op_writes(instr[6:0]);
      m_cycle++;
      if (valid) m_instret++;
      m_cv  = valid;
      m_cpc = pc;
      m_crd = we ? rd : 5'd0;
      m_cwd = (we && rd != 0) ? memory_out : 32'd0;
      if (valid && instr == EBREAK) begin
        m_halt  = 1;
        m_hcode = m_regs[10];
      end
      if (we && rd != 0) m_regs[rd] = memory_out;
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] m, input logic [4:0] a1, input logic [4:0] a2);
    valid = v; instr = i; pc = p; memory_out = m; raddr1 = a1; raddr2 = a2;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 0;
    drive(0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd10);
    #1;
    model_reset();
    n_vec++;
    if (obs() !== expv() || obs() !== '0) begin
      n_err++; $display("FAIL reset_state got=%h want=%h", obs(), expv());
    end
    n_vec++;
    if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
      n_err++; $display("FAIL reset_reads got=%h/%h want=0/0", rdata1, rdata2);
    end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_idle_cycles();
    for (int k = 0; k < 3; k++) step();
    n_vec++;
    if (cycle_cnt !== 64'd3 || instret_cnt !== 64'd0 || commit_valid !== 1'b0) begin
      n_err++; $display("FAIL idle_counters got cyc=%0d ret=%0d cv=%b want 3/0/0", cycle_cnt, instret_cnt, commit_valid);
    end
    n_vec++;
    if (obs() !== expv()) begin
      n_err++; $display("FAIL idle_state got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_addi_x5();
    logic [63:0] ret0;
    ret0 = m_instret;
    drive(1, 32'h00A0_0293, 32'h0000_1000, 32'hA, 5'd5, 5'd0);
    #1;
    n_vec++;
    if (rdata1 !== m_regs[5] || rdata1 !== 32'd0) begin
      n_err++; $display("FAIL addi_no_bypass got=%h want=0", rdata1);
    end
    step();
    n_vec++;
    if (rdata1 !== 32'hA || commit_valid !== 1'b1 || commit_rd !== 5'd5 ||
        commit_wdata !== 32'hA || instret_cnt !== ret0 + 1) begin
      n_err++; $display("FAIL addi_commit got rd1=%h cv=%b crd=%0d cwd=%h ret=%0d", rdata1, commit_valid, commit_rd, commit_wdata, instret_cnt);
    end
    n_vec++;
    if (obs() !== expv()) begin
      n_err++; $display("FAIL addi_state got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_x0_and_store();
    logic [63:0] ret0;
    ret0 = m_instret;
    drive(1, 32'h00A0_0013, 32'h0000_1004, 32'h55, 5'd0, 5'd5);
    step();
    n_vec++;
    if (rdata1 !== 32'd0 || commit_rd !== 5'd0 || commit_wdata !== 32'd0 || instret_cnt !== ret0 + 1) begin
      n_err++; $display("FAIL x0_write got x0=%h crd=%0d cwd=%h ret=%0d", rdata1, commit_rd, commit_wdata, instret_cnt);
    end
    drive(1, 32'h0062_A023, 32'h0000_1008, 32'h1234, 5'd5, 5'd6);
    step();
    n_vec++;
    if (rdata1 !== m_regs[5] || rdata2 !== m_regs[6] || commit_rd !== 5'd0 || instret_cnt !== ret0 + 2) begin
      n_err++; $display("FAIL store_nowrite got x5=%h x6=%h crd=%0d ret=%0d", rdata1, rdata2, commit_rd, instret_cnt);
    end
    n_vec++;
    if (obs() !== expv()) begin
      n_err++; $display("FAIL store_state got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [11];
    logic [31:0] r, ins;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0010011,
            7'b0110011, 7'b0100011, 7'b1100011, 7'b1110011, 7'b0000000};
    for (int k = 0; k < 300; k++) begin
      r   = $urandom;
      ins = {r[31:12], 5'($urandom_range(0, 31)), ops[$urandom_range(0, 10)]};
      if (ins == EBREAK) ins = ins ^ 32'h0000_1000;
      drive(1'($urandom_range(0, 3) != 0), ins, $urandom, $urandom,
            5'($urandom_range(0, 31)), ins[11:7]);
      #1;
      n_vec++;
      if (rdata1 !== m_regs[raddr1] || rdata2 !== m_regs[raddr2]) begin
        n_err++; $display("FAIL rand_read k=%0d got=%h/%h want=%h/%h", k, rdata1, rdata2, m_regs[raddr1], m_regs[raddr2]);
      end
      step();
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL rand_state k=%0d got=%h want=%h", k, obs(), expv());
      end
    end
  endtask

  task automatic test_halt();
    logic [31:0] x5;
    logic [63:0] cyc, ret;
    drive(1, 32'h0000_2503, 32'h0000_2000, 32'h2A, 5'd10, 5'd0);
    step();
    drive(1, EBREAK, 32'h0000_2004, 32'hDEAD_BEEF, 5'd10, 5'd0);
    step();
    n_vec++;
    if (halt !== 1'b1 || halt_code !== 32'h2A || commit_valid !== 1'b1) begin
      n_err++; $display("FAIL ebreak_halt got halt=%b code=%h cv=%b want 1/2a/1", halt, halt_code, commit_valid);
    end
    n_vec++;
    if (obs() !== expv()) begin
      n_err++; $display("FAIL ebreak_state got=%h want=%h", obs(), expv());
    end
    x5 = m_regs[5]; cyc = m_cycle; ret = m_instret;
    drive(1, 32'h00A0_0293, 32'h0000_2008, 32'h7, 5'd5, 5'd10);
    step();
    step();
    n_vec++;
    if (rdata1 !== x5 || cycle_cnt !== cyc || instret_cnt !== ret || commit_valid !== 1'b0) begin
      n_err++; $display("FAIL halted_frozen got x5=%h cyc=%0d ret=%0d cv=%b", rdata1, cycle_cnt, instret_cnt, commit_valid);
    end
    n_vec++;
    if (obs() !== expv()) begin
      n_err++; $display("FAIL halted_state got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_async_reset();
    drive(0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd10);
    #2;
    rst = 0;
    #1;
    model_reset();
    n_vec++;
    if (obs() !== expv() || rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
      n_err++; $display("FAIL async_reset got=%h rd=%h/%h want=%h rd=0/0", obs(), rdata1, rdata2, expv());
    end
    @(negedge clk);
    rst = 1;
    drive(1, 32'h00A0_0293, 32'h0000_1000, 32'hA, 5'd5, 5'd0);
    step();
    n_vec++;
    if (rdata1 !== 32'hA || obs() !== expv()) begin
      n_err++; $display("FAIL post_reset_addi got x5=%h st=%h want x5=a st=%h", rdata1, obs(), expv());
    end
  endtask

  initial begin
    rst = 1;
    drive(0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    model_reset();
    test_reset();
    test_idle_cycles();
    test_addi_x5();
    test_x0_and_store();
    test_random();
    test_halt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
